// File: rtl/alu_issue_decoder_pkg.sv
// Shared constants and types for the ALU issue decoder.
//  - Datapath / register-file widths.
//  - ALU operation codes (ALU_OP_*). Code 0 is reserved for "no operation",
//    so an illegal instruction leaves alu_op at 0.
//  - RV32I opcode / funct7 constants used by the decoder.
//  - Payload struct carried from decode to EX, and the buffer FSM states.
package alu_issue_decoder_pkg;

    localparam int XLEN              = 32;
    localparam int DATA_WIDTH_GPR    = XLEN;
    localparam int REG_ADDR_W        = 5;
    localparam int DATA_WIDTH_ALU_OP = 5;

    typedef logic [DATA_WIDTH_ALU_OP-1:0] alu_op_t;

    localparam alu_op_t ALU_OP_NONE  = 5'd0;
    localparam alu_op_t ALU_OP_ADD   = 5'd1;
    localparam alu_op_t ALU_OP_SUB   = 5'd2;
    localparam alu_op_t ALU_OP_SLL   = 5'd3;
    localparam alu_op_t ALU_OP_SLT   = 5'd4;
    localparam alu_op_t ALU_OP_SLTU  = 5'd5;
    localparam alu_op_t ALU_OP_XOR   = 5'd6;
    localparam alu_op_t ALU_OP_SRL   = 5'd7;
    localparam alu_op_t ALU_OP_SRA   = 5'd8;
    localparam alu_op_t ALU_OP_OR    = 5'd9;
    localparam alu_op_t ALU_OP_AND   = 5'd10;
    localparam alu_op_t ALU_OP_ADDI  = 5'd11;
    localparam alu_op_t ALU_OP_SLTI  = 5'd12;
    localparam alu_op_t ALU_OP_SLTIU = 5'd13;
    localparam alu_op_t ALU_OP_XORI  = 5'd14;
    localparam alu_op_t ALU_OP_ORI   = 5'd15;
    localparam alu_op_t ALU_OP_ANDI  = 5'd16;
    localparam alu_op_t ALU_OP_SLLI  = 5'd17;
    localparam alu_op_t ALU_OP_SRLI  = 5'd18;
    localparam alu_op_t ALU_OP_SRAI  = 5'd19;
    localparam alu_op_t ALU_OP_LUI   = 5'd20;
    localparam alu_op_t ALU_OP_AUIPC = 5'd21;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    typedef struct packed {
        alu_op_t                 alu_op;
        logic [XLEN-1:0]         in0;
        logic [XLEN-1:0]         in1;
        logic [REG_ADDR_W-1:0]   rd_addr;
        logic                    rd_we;
        logic                    illegal;
        logic [XLEN-1:0]         pc;
    } issue_payload_t;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_t;

endpackage

// File: rtl/alu_issue_decoder_id_alu_decode.sv
// id_alu_decode: purely combinational RV32I OP / OP-IMM / LUI / AUIPC decoder.
// Ports:
//  insn     in   raw 32-bit instruction
//  pc       in   pc of insn
//  rs1_data in   register-file data for insn[19:15]
//  rs2_data in   register-file data for insn[24:20]
//  payload  out  alu_op, operands, rd, write enable, illegal flag, pc
// Operand convention: immediates (and the upper immediate) go on in0; the
// register/pc operand goes on in1. Illegal encodings produce all-zero op and operands.
module id_alu_decode
    import alu_issue_decoder_pkg::*;
(
    input  logic [31:0]     insn,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output issue_payload_t  payload
);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] shamt;
    logic [XLEN-1:0] imm_u;
    logic            legal;
    alu_op_t         op;
    logic [XLEN-1:0] in0;
    logic [XLEN-1:0] in1;

    assign opcode = insn[6:0];
    assign funct3 = insn[14:12];
    assign funct7 = insn[31:25];
    assign imm_i  = {{(XLEN-12){insn[31]}}, insn[31:20]};
    assign shamt  = {{(XLEN-5){1'b0}}, insn[24:20]};
    // Unshifted upper immediate; the ALU applies the <<12 itself.
    assign imm_u  = {{(XLEN-20){1'b0}}, insn[31:12]};

    always_comb begin
        legal = 1'b0;
        op    = ALU_OP_NONE;
        in0   = '0;
        in1   = '0;
        unique case (opcode)
            OPC_OP_IMM: begin
                unique case (funct3)
                    3'b000: begin legal = 1'b1; op = ALU_OP_ADDI;  in0 = imm_i; in1 = rs1_data; end
                    3'b010: begin legal = 1'b1; op = ALU_OP_SLTI;  in0 = imm_i; in1 = rs1_data; end
                    3'b011: begin legal = 1'b1; op = ALU_OP_SLTIU; in0 = imm_i; in1 = rs1_data; end
                    3'b100: begin legal = 1'b1; op = ALU_OP_XORI;  in0 = imm_i; in1 = rs1_data; end
                    3'b110: begin legal = 1'b1; op = ALU_OP_ORI;   in0 = imm_i; in1 = rs1_data; end
                    3'b111: begin legal = 1'b1; op = ALU_OP_ANDI;  in0 = imm_i; in1 = rs1_data; end
                    3'b001: begin
                        if (funct7 == FUNCT7_BASE) begin
                            legal = 1'b1; op = ALU_OP_SLLI; in0 = shamt; in1 = rs1_data;
                        end
                    end
                    default: begin // 3'b101
                        if (funct7 == FUNCT7_BASE) begin
                            legal = 1'b1; op = ALU_OP_SRLI; in0 = shamt; in1 = rs1_data;
                        end else if (funct7 == FUNCT7_ALT) begin
                            legal = 1'b1; op = ALU_OP_SRAI; in0 = shamt; in1 = rs1_data;
                        end
                    end
                endcase
            end
            OPC_OP: begin
                if (funct7 == FUNCT7_BASE) begin
                    legal = 1'b1;
                    in0   = rs1_data;
                    in1   = rs2_data;
                    unique case (funct3)
                        3'b000:  op = ALU_OP_ADD;
                        3'b001:  op = ALU_OP_SLL;
                        3'b010:  op = ALU_OP_SLT;
                        3'b011:  op = ALU_OP_SLTU;
                        3'b100:  op = ALU_OP_XOR;
                        3'b101:  op = ALU_OP_SRL;
                        3'b110:  op = ALU_OP_OR;
                        default: op = ALU_OP_AND;
                    endcase
                end else if (funct7 == FUNCT7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)) begin
                    legal = 1'b1;
                    in0   = rs1_data;
                    in1   = rs2_data;
                    op    = (funct3 == 3'b000) ? ALU_OP_SUB : ALU_OP_SRA;
                end
            end
            OPC_LUI: begin
                legal = 1'b1; op = ALU_OP_LUI; in0 = imm_u; in1 = '0;
            end
            OPC_AUIPC: begin
                legal = 1'b1; op = ALU_OP_AUIPC; in0 = imm_u; in1 = pc;
            end
            default: ;
        endcase
    end

    always_comb begin
        payload         = '0;
        payload.alu_op  = op;
        payload.in0     = in0;
        payload.in1     = in1;
        payload.rd_addr = insn[11:7];
        payload.rd_we   = legal && (insn[11:7] != '0);
        payload.illegal = ~legal;
        payload.pc      = pc;
    end

endmodule

// File: rtl/alu_issue_decoder.sv
// alu_issue_decoder: ID-stage producer for the EX-stage ALU.
// Decodes the incoming instruction with id_alu_decode and buffers the result in a
// main + skid register pair with valid/ready handshakes on both sides.
// Ports:
//  clk, rst                 clock, asynchronous active-high reset
//  if_valid/if_ready        fetch-side handshake (if_ready = skid empty)
//  if_pc, if_insn           instruction and its pc
//  rs1_addr, rs2_addr       combinational register-file read addresses
//  rs1_data, rs2_data       register-file read data (same cycle)
//  flush                    synchronous kill of buffered and incoming work
//  ex_valid/ex_ready        EX-side handshake
//  ex_alu_op .. ex_pc       buffered decode payload (main register)
module alu_issue_decoder
    import alu_issue_decoder_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         if_valid,
    output logic                         if_ready,
    input  logic [XLEN-1:0]              if_pc,
    input  logic [31:0]                  if_insn,
    output logic [REG_ADDR_W-1:0]        rs1_addr,
    output logic [REG_ADDR_W-1:0]        rs2_addr,
    input  logic [XLEN-1:0]              rs1_data,
    input  logic [XLEN-1:0]              rs2_data,
    input  logic                         flush,
    output logic                         ex_valid,
    input  logic                         ex_ready,
    output logic [DATA_WIDTH_ALU_OP-1:0] ex_alu_op,
    output logic [XLEN-1:0]              ex_alu_in_0,
    output logic [XLEN-1:0]              ex_alu_in_1,
    output logic [REG_ADDR_W-1:0]        ex_rd_addr,
    output logic                         ex_rd_we,
    output logic                         ex_illegal,
    output logic [XLEN-1:0]              ex_pc
);

    buf_state_t     state_reg;
    buf_state_t     state_next;
    issue_payload_t main_reg;
    issue_payload_t skid_reg;
    issue_payload_t dec_payload;
    logic           accept;
    logic           consume;
    logic           load_main_dec;
    logic           load_main_skid;
    logic           load_skid_dec;

    assign rs1_addr = if_insn[19:15];
    assign rs2_addr = if_insn[24:20];

    id_alu_decode u_decode (
        .insn     (if_insn),
        .pc       (if_pc),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .payload  (dec_payload)
    );

    // A handshake coinciding with flush is dropped, so it never counts as an accept.
    assign accept  = if_valid && if_ready && !flush;
    assign consume = ex_valid && ex_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= BUF_EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        load_main_dec  = 1'b0;
        load_main_skid = 1'b0;
        load_skid_dec  = 1'b0;
        if (flush) begin
            state_next = BUF_EMPTY;
        end else begin
            unique case (state_reg)
                BUF_EMPTY: begin
                    if (accept) begin
                        state_next    = BUF_ONE;
                        load_main_dec = 1'b1;
                    end
                end
                BUF_ONE: begin
                    if (consume && accept) begin
                        load_main_dec = 1'b1;
                    end else if (consume) begin
                        state_next = BUF_EMPTY;
                    end else if (accept) begin
                        state_next    = BUF_TWO;
                        load_skid_dec = 1'b1;
                    end
                end
                default: begin // BUF_TWO: no accept possible, skid drains into main
                    if (consume) begin
                        state_next     = BUF_ONE;
                        load_main_skid = 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        ex_valid = (state_reg != BUF_EMPTY);
        if_ready = (state_reg != BUF_TWO);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_reg <= '0;
            skid_reg <= '0;
        end else begin
            if (load_main_dec) begin
                main_reg <= dec_payload;
            end else if (load_main_skid) begin
                main_reg <= skid_reg;
            end
            if (load_skid_dec) begin
                skid_reg <= dec_payload;
            end
        end
    end

    assign ex_alu_op   = main_reg.alu_op;
    assign ex_alu_in_0 = main_reg.in0;
    assign ex_alu_in_1 = main_reg.in1;
    assign ex_rd_addr  = main_reg.rd_addr;
    assign ex_rd_we    = main_reg.rd_we;
    assign ex_illegal  = main_reg.illegal;
    assign ex_pc       = main_reg.pc;

endmodule
